// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO APB register slave.
//   - byte offsets of every register in the map (decoded on PADDR[5:2])
//   - bus-side FSM state encoding (IDLE / RD_WAIT / RD_DONE)
//   - bit position of the global interrupt enable inside CTRL
package gpio_pkg;

    localparam logic [5:0] GPIO_DIR_OFS      = 6'h00;
    localparam logic [5:0] GPIO_OUT_OFS      = 6'h04;
    localparam logic [5:0] GPIO_IN_OFS       = 6'h08;
    localparam logic [5:0] GPIO_INT_EN_OFS   = 6'h0C;
    localparam logic [5:0] GPIO_INT_TYPE_OFS = 6'h10;
    localparam logic [5:0] GPIO_INT_POL_OFS  = 6'h14;
    localparam logic [5:0] GPIO_INT_STAT_OFS = 6'h18;
    localparam logic [5:0] GPIO_OUT_SET_OFS  = 6'h1C;
    localparam logic [5:0] GPIO_OUT_CLR_OFS  = 6'h20;
    localparam logic [5:0] GPIO_CTRL_OFS     = 6'h24;

    localparam int GPIO_CTRL_GIE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } gpio_state_e;

endpackage

// File: rtl/gpio_apb_regs.sv
// gpio_apb_regs: APB3 register slave in front of the GPIO pin controller.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   psel .. pwdata    APB3 request side
//   prdata, pready,   APB3 response side; writes complete with zero wait
//   pslverr           states, reads with one wait state
//   gpio_dir/out      direction and output registers to the controller
//   gpio_in           raw pin values from the controller (read via IN)
//   int_enable/type/  interrupt configuration to the controller
//   int_polarity
//   int_status        interrupt status from the controller (read via INT_STAT)
//   int_clear         one-cycle W1C pulse to the controller
//   int_out, irq      controller interrupt in, gated/registered CPU irq out
//
// Handshake: an access is the cycle(s) where psel & penable are high; the
// transfer completes at the clk edge where pready is high. Writes complete in
// their first access cycle; reads see pready=0, then pready=1 with prdata.
//
// Build option: GPIO_APB_REGS_PSLVERR_EN enables pslverr for undefined
// offsets and writes to IN. Without it pslverr is tied low and such writes
// are silently dropped.
module gpio_apb_regs
    import gpio_pkg::*;
#(
    parameter int PIN_COUNT  = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [PIN_COUNT-1:0]  gpio_dir,
    output logic [PIN_COUNT-1:0]  gpio_out,
    input  logic [PIN_COUNT-1:0]  gpio_in,
    output logic [PIN_COUNT-1:0]  int_enable,
    output logic [PIN_COUNT-1:0]  int_type,
    output logic [PIN_COUNT-1:0]  int_polarity,
    input  logic [PIN_COUNT-1:0]  int_status,
    output logic [PIN_COUNT-1:0]  int_clear,
    input  logic                  int_out,
    output logic                  irq
);

    gpio_state_e state, state_next;

    logic [5:0]           ofs;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 ofs_defined;
    logic                 acc_err;
    logic                 wr_en;
    logic [PIN_COUNT-1:0] wdata;
    logic [31:0]          rd_mux;
    logic                 gie;

    // Only PADDR[5:2] selects a register; the remaining address bits and
    // the write-data bits above PIN_COUNT are don't-care.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{paddr, pwdata};

    assign ofs    = {paddr[5:2], 2'b00};
    assign wdata  = pwdata[PIN_COUNT-1:0];
    assign wr_acc = (state == IDLE) && psel && penable && pwrite;
    assign rd_acc = (state == IDLE) && psel && penable && !pwrite;

    always_comb begin
        ofs_defined = 1'b0;
        case (ofs)
            GPIO_DIR_OFS, GPIO_OUT_OFS, GPIO_IN_OFS, GPIO_INT_EN_OFS,
            GPIO_INT_TYPE_OFS, GPIO_INT_POL_OFS, GPIO_INT_STAT_OFS,
            GPIO_OUT_SET_OFS, GPIO_OUT_CLR_OFS, GPIO_CTRL_OFS:
                ofs_defined = 1'b1;
            default: ofs_defined = 1'b0;
        endcase
    end

`ifdef GPIO_APB_REGS_PSLVERR_EN
    logic rd_err_q;

    assign acc_err = !ofs_defined || (pwrite && (ofs == GPIO_IN_OFS));
    // Write errors answer in the same cycle; read errors are held until the
    // RD_WAIT cycle where pready goes high.
    assign pslverr = (wr_acc && acc_err) || ((state == RD_WAIT) && rd_err_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else if (rd_acc) begin
            rd_err_q <= acc_err;
        end
    end
`else
    logic unused_ofs_defined;
    assign unused_ofs_defined = ofs_defined;
    assign acc_err = 1'b0;
    assign pslverr = 1'b0;
`endif

    assign wr_en = wr_acc && !acc_err;

    // Read mux; write-only and undefined offsets read as zero.
    always_comb begin
        rd_mux = 32'h0;
        case (ofs)
            GPIO_DIR_OFS:      rd_mux = 32'(gpio_dir);
            GPIO_OUT_OFS:      rd_mux = 32'(gpio_out);
            GPIO_IN_OFS:       rd_mux = 32'(gpio_in);
            GPIO_INT_EN_OFS:   rd_mux = 32'(int_enable);
            GPIO_INT_TYPE_OFS: rd_mux = 32'(int_type);
            GPIO_INT_POL_OFS:  rd_mux = 32'(int_polarity);
            GPIO_INT_STAT_OFS: rd_mux = 32'(int_status);
            GPIO_CTRL_OFS:     rd_mux = 32'(gie) << GPIO_CTRL_GIE_BIT;
            default:           rd_mux = 32'h0;
        endcase
    end

    // Bus FSM: RD_DONE inserts a dead cycle after each read so a master that
    // keeps psel/penable high is not answered twice for one transfer.
    always_comb begin
        state_next = state;
        pready     = 1'b0;
        case (state)
            IDLE: begin
                pready = wr_acc;
                if (rd_acc) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                pready     = 1'b1;
                state_next = RD_DONE;
            end
            RD_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prdata       <= 32'h0;
            gpio_dir     <= '0;
            gpio_out     <= '0;
            int_enable   <= '0;
            int_type     <= '0;
            int_polarity <= '0;
            int_clear    <= '0;
            gie          <= 1'b0;
            irq          <= 1'b0;
        end else begin
            state     <= state_next;
            int_clear <= '0;
            irq       <= int_out && gie;
            if (rd_acc) begin
                prdata <= rd_mux;
            end
            if (wr_en) begin
                case (ofs)
                    GPIO_DIR_OFS:      gpio_dir     <= wdata;
                    GPIO_OUT_OFS:      gpio_out     <= wdata;
                    GPIO_INT_EN_OFS:   int_enable   <= wdata;
                    GPIO_INT_TYPE_OFS: int_type     <= wdata;
                    GPIO_INT_POL_OFS:  int_polarity <= wdata;
                    GPIO_INT_STAT_OFS: int_clear    <= wdata;
                    GPIO_OUT_SET_OFS:  gpio_out     <= gpio_out | wdata;
                    GPIO_OUT_CLR_OFS:  gpio_out     <= gpio_out & ~wdata;
                    GPIO_CTRL_OFS:     gie          <= pwdata[GPIO_CTRL_GIE_BIT];
                    default:           ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_apb_regs.sv
// tb_gpio_apb_regs: self-checking bench for gpio_apb_regs (PIN_COUNT=32).
// Directed checks for reset, the register map, W1C pulses, irq gating and
// protocol corner cases, then randomized accesses against a register model.
// Build option GPIO_APB_REGS_PSLVERR_EN changes the expected pslverr.
module tb_gpio_apb_regs;

    localparam int PC = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [7:0]    paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [PC-1:0] gpio_dir, gpio_out, gpio_in;
    logic [PC-1:0] int_enable, int_type, int_polarity, int_status, int_clear;
    logic          int_out, irq;

    int total = 0;
    int bad   = 0;

    // Register model: one variable per software-visible register.
    logic [31:0] m_dir, m_out, m_ien, m_ity, m_ipol;
    logic        m_gie;

    always #5 clk = ~clk;

    gpio_apb_regs #(.PIN_COUNT(PC), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .gpio_dir(gpio_dir), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .int_enable(int_enable), .int_type(int_type),
        .int_polarity(int_polarity), .int_status(int_status),
        .int_clear(int_clear), .int_out(int_out), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_out = 0; m_ien = 0; m_ity = 0; m_ipol = 0; m_gie = 0;
    endtask

    function automatic logic model_err(input logic [7:0] a, input logic wr);
`ifdef GPIO_APB_REGS_PSLVERR_EN
        return (a[5:2] > 4'd9) || (wr && a[5:2] == 4'd2);
`else
        return 1'b0;
`endif
    endfunction

    // Register index = byte offset / 4; indices 10..15 are holes in the map.
    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a[5:2])
            4'd0: return m_dir;
            4'd1: return m_out;
            4'd2: return gpio_in;
            4'd3: return m_ien;
            4'd4: return m_ity;
            4'd5: return m_ipol;
            4'd6: return int_status;
            4'd9: return {31'b0, m_gie};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        if (model_err(a, 1'b1)) return;
        case (a[5:2])
            4'd0: m_dir  = d;
            4'd1: m_out  = d;
            4'd3: m_ien  = d;
            4'd4: m_ity  = d;
            4'd5: m_ipol = d;
            4'd7: m_out  = m_out | d;
            4'd8: m_out  = m_out & ~d;
            4'd9: m_gie  = d[0];
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        chk("gpio_dir",     gpio_dir,     m_dir);
        chk("gpio_out",     gpio_out,     m_out);
        chk("int_enable",   int_enable,   m_ien);
        chk("int_type",     int_type,     m_ity);
        chk("int_polarity", int_polarity, m_ipol);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        logic err;
        err = model_err(a, 1'b1);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        #1;
        chk("wr_pready",  pready,  1);
        chk("wr_pslverr", pslverr, err);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        model_write(a, d);
        chk("int_clear", int_clear, (a[5:2] == 4'd6 && !err) ? d : 32'h0);
        check_outputs();
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        logic [31:0] exp;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1;
        penable = 1;
        #1;
        chk("rd_pready_wait", pready, 0);
        exp = model_read(a);
        @(posedge clk); #1;
        chk("rd_pready",  pready,  1);
        chk("rd_pslverr", pslverr, model_err(a, 1'b0));
        chk("rd_data",    prdata,  exp);
        d = prdata;
        @(posedge clk); #1;
        psel = 0; penable = 0;
        chk("rd_done_pready", pready, 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a;
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        gpio_in = 0; int_status = 0; int_out = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready",    pready,    0);
        chk("rst_prdata",    prdata,    0);
        chk("rst_int_clear", int_clear, 0);
        chk("rst_irq",       irq,       0);
        check_outputs();
        rst = 0;

        // Every defined offset reads zero after reset.
        for (int i = 0; i < 10; i++) apb_read(8'(i * 4), d);

        // DIR / OUT with set and clear aliases.
        apb_write(8'h00, 32'h0000_00FF);
        apb_write(8'h04, 32'h0000_00A5);
        apb_write(8'h1C, 32'h0000_0100);
        apb_write(8'h20, 32'h0000_0005);
        chk("dir_ff",   gpio_dir, 32'hFF);
        chk("out_1a0",  gpio_out, 32'h1A0);
        apb_read(8'h04, d);
        chk("out_rdbk", d, 32'h0000_01A0);

        // IN sampling.
        gpio_in = 32'hDEAD_BEEF;
        apb_read(8'h08, d);
        chk("in_rd", d, 32'hDEAD_BEEF);

        // INT_STAT read and W1C pulse width.
        int_status = 32'h0000_0011;
        apb_read(8'h18, d);
        chk("stat_rd", d, 32'h11);
        apb_write(8'h18, 32'h01);
        chk("clr_pulse", int_clear, 32'h01);
        @(posedge clk); #1;
        chk("clr_end", int_clear, 0);

        // irq gating by GIE with one cycle of latency.
        int_out = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_gie0", irq, 0);
        apb_write(8'h24, 32'h1);
        chk("irq_lat", irq, 0);
        @(posedge clk); #1;
        chk("irq_on", irq, 1);
        int_out = 0;
        @(posedge clk); #1;
        chk("irq_off", irq, 0);
        apb_read(8'h24, d);
        chk("ctrl_rd", d, 32'h1);

        // Undefined offset and write to IN: pslverr depends on build, no state change.
        apb_write(8'h30, 32'hFFFF_FFFF);
        apb_write(8'h08, 32'h1234_5678);
        apb_read(8'h30, d);
        chk("undef_rd", d, 0);

        // Randomized accesses, including ignored address bits.
        for (int n = 0; n < 80; n++) begin
            gpio_in    = $urandom;
            int_status = $urandom;
            a = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 2) != 0) apb_write(a, $urandom);
            else apb_read(a, d);
        end

        // psel dropped during a read: the FSM still finishes the read.
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 8'h04;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0;
        chk("drop_wait_pready", pready, 1);
        chk("drop_prdata", prdata, m_out);
        @(posedge clk); #1;
        chk("drop_done_pready", pready, 0);
        check_outputs();
        apb_write(8'h00, 32'h5A5A_0F0F);

        // Reset in the middle of a read.
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = 8'h00;
        @(posedge clk); #1;
        penable = 1; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("rstmid_pready", pready, 0);
        chk("rstmid_prdata", prdata, 0);
        psel = 0; penable = 0;
        check_outputs();
        apb_read(8'h00, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_apb_regs.md
Name: gpio_apb_regs

Overview:
- APB3 register slave that acts as the host-side front end of the GPIO pin controller.
- Holds the direction, output and interrupt-configuration registers and drives them onto the controller's control inputs.
- Returns synchronized pin input values and interrupt status to software.
- Converts write-1-to-clear accesses into single-cycle int_clear pulses; gates the controller's interrupt into the CPU irq line.

Parameters:
- PIN_COUNT, 32, number of GPIO pins (1..32); register bits above PIN_COUNT read 0 and ignore writes
- ADDR_WIDTH, 8, PADDR width; only PADDR[5:2] is decoded, PADDR[1:0] is ignored

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset; synchronous and active-high
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  32  write data
- prdata  out  32  read data, valid when pready=1 in a read access
- pready  out  1  transfer complete
- pslverr  out  1  error response (see Optional Feature)
- gpio_dir  out  PIN_COUNT  to controller; 1=output
- gpio_out  out  PIN_COUNT  to controller; output values
- gpio_in  in  PIN_COUNT  from controller; raw pin values
- int_enable  out  PIN_COUNT  to controller
- int_type  out  PIN_COUNT  to controller; 1=edge
- int_polarity  out  PIN_COUNT  to controller; 1=high/rising
- int_status  in  PIN_COUNT  from controller
- int_clear  out  PIN_COUNT  to controller; one-cycle pulse
- int_out  in  1  controller OR of status
- irq  out  1  registered int_out & GIE

Behaviour:
- Register map (offsets):
  - 0x00 DIR rw
  - 0x04 OUT rw
  - 0x08 IN ro
  - 0x0C INT_EN rw
  - 0x10 INT_TYPE rw
  - 0x14 INT_POL rw
  - 0x18 INT_STAT r/W1C
  - 0x1C OUT_SET wo
  - 0x20 OUT_CLR wo
  - 0x24 CTRL: bit0 = GIE, rw
  - All other offsets are undefined.
- Reset (rst=1 at a clk edge):
  - all rw registers, int_clear, irq, prdata: 0
  - pready: 0
  - pslverr: 0
  - FSM: IDLE
- FSM states: IDLE, RD_WAIT, RD_DONE.
- Writes, zero wait states:
  - In IDLE, psel&penable&pwrite: pready=1 combinationally in that cycle; the register updates at the same clk edge; FSM stays IDLE.
  - OUT_SET: OUT |= pwdata.
  - OUT_CLR: OUT &= ~pwdata.
- Reads, one wait state:
  - In IDLE, psel&penable&!pwrite: pready=0; the IN/INT_STAT sample and mux are registered into prdata; go to RD_WAIT.
  - RD_WAIT: pready=1 and prdata is valid; go to RD_DONE.
  - RD_DONE: pready=0; return to IDLE. This blocks a back-to-back access from being mistaken for the same transfer.
  - Reads of wo and undefined offsets return 0.
- W1C: a write to INT_STAT drives int_clear = pwdata[PIN_COUNT-1:0] for exactly the cycle after the write edge, then 0. Zero bits produce no pulse.
- Simultaneous events:
  - If the controller sets a status bit in the same cycle a clear pulse is asserted, the controller's priority applies (clear wins). The block does no extra arbitration.
  - OUT_SET/OUT_CLR only ever affect the addressed register.
- irq: registered; irq = int_out & CTRL.GIE, one clk of latency.
- psel deasserted mid-read (protocol violation): the FSM still completes RD_WAIT→RD_DONE→IDLE with no side effects.
- Reset mid-read: the FSM returns to IDLE and pready=0 on the next cycle.

Optional Feature:
- Macro: GPIO_APB_REGS_PSLVERR_EN.
- Defined: pslverr=1 together with pready=1 when either:
  - the access is to an undefined offset, or
  - the access writes to IN (0x08).
  - Erroring writes change no state; erroring reads return 0.
- Undefined: pslverr is tied 0; such writes are silently ignored.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset localparams (GPIO_DIR_OFS ... GPIO_CTRL_OFS)
  - the FSM state enum (IDLE/RD_WAIT/RD_DONE)
  - the CTRL bit index constant
- No sub-module; the register file and FSM stay in one module.

Test Plan:
- Reset, then read every offset 0x00–0x24: DIR/OUT/INT_*/CTRL = 0; pready is low in the first access cycle and high in the second.
- Write DIR=0x0000_00FF, OUT=0x0000_00A5, then OUT_SET=0x0000_0100 and OUT_CLR=0x0000_0005 → gpio_dir=0xFF, gpio_out=0x1A0; OUT reads back 0x0000_01A0.
- Drive gpio_in=0xDEAD_BEEF, read IN → prdata=0xDEADBEEF on the pready cycle.
- Set int_status=0x0000_0011, read INT_STAT → 0x11; write INT_STAT=0x01 → int_clear=0x01 for exactly 1 cycle, then 0.
- int_out=1 with CTRL=0 → irq stays 0; write CTRL=1 → irq=1 one cycle later; int_out falls → irq=0 one cycle later.
- With GPIO_APB_REGS_PSLVERR_EN defined:
  - write 0x30 → pslverr=1 and pready=1, no state change;
  - write IN → pslverr=1;
  - without the macro, both accesses give pslverr=0 and no state change.
